// File: rtl/csa_serial_multiplier_if.sv
// Bus bundle for the carry-save serial multiplier.
//
// Handshake: start is a request sampled only when the core is IDLE or DONE,
// and the operands are captured on that same edge. busy is high for the
// WIDTH cycles of RUN. done is a one-cycle valid pulse. There is no
// backpressure: sum/carry hold their value from done until the next accepted
// start, so a consumer may read them during or after the pulse.
// dbg_state mirrors the controller state (0=IDLE, 1=RUN, 2=DONE).
interface csa_serial_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     sum;
  logic [2*WIDTH-1:0]     carry;
  logic [1:0]             dbg_state;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  sum,
    input  carry,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output sum,
    output carry,
    output dbg_state
  );
endinterface

// File: rtl/csa_serial_multiplier.sv
// Signed serial-parallel multiplier in carry-save form.
// One multiplier bit is consumed per clock; partial products are folded into
// a redundant (sum, carry) pair with a single 3:2 compressor row, so no carry
// ever ripples inside the loop. The product is sum + (carry << 1), mod 2^(2W).
// The multiplier sign bit carries negative weight, so on the last step the
// pre-negated multiplicand is accumulated instead of the multiplicand itself.
module csa_serial_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  csa_serial_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;        // multiplicand
  logic [WIDTH:0]    negx_q, negx_d;  // -X, one extra bit so -(-2^(W-1)) fits
  logic [WIDTH-1:0]  y_q, y_d;        // multiplier, shifted right each step
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     sum_q, sum_d;
  logic [PW-1:0]     carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Datapath helpers for the current step.
  logic [PW-1:0]     x_ext;
  logic [PW-1:0]     negx_ext;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     csa_a;
  logic [PW-1:0]     csa_b;

  // Partial product for the bit at the bottom of the multiplier shift register.
  always_comb begin
    x_ext    = {{WIDTH{x_q[WIDTH-1]}}, x_q};
    negx_ext = {{(WIDTH-1){negx_q[WIDTH]}}, negx_q};
    pp       = '0;
    if (y_q[0]) begin
      if (count_q == LAST) begin
        pp = negx_ext << count_q;
      end else begin
        pp = x_ext << count_q;
      end
    end
    csa_a = sum_q;
    csa_b = {carry_q[PW-2:0], 1'b0};
  end

  // Next-state and next-register computation for controller and datapath.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    negx_d  = negx_q;
    y_d     = y_q;
    count_d = count_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = S_RUN;
          x_d     = bus.multiplicand;
          negx_d  = -{bus.multiplicand[WIDTH-1], bus.multiplicand};
          y_d     = bus.multiplier;
          count_d = '0;
          sum_d   = '0;
          carry_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        // start is deliberately not looked at here.
        sum_d   = csa_a ^ csa_b ^ pp;
        carry_d = (csa_a & csa_b) | (csa_a & pp) | (csa_b & pp);
        y_d     = y_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // Back-to-back accept: reload straight from DONE, no IDLE bubble.
          state_d = S_RUN;
          x_d     = bus.multiplicand;
          negx_d  = -{bus.multiplicand[WIDTH-1], bus.multiplicand};
          y_d     = bus.multiplier;
          count_d = '0;
          sum_d   = '0;
          carry_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      negx_q  <= '0;
      y_q     <= '0;
      count_q <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      negx_q  <= negx_d;
      y_q     <= y_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_csa_serial_multiplier.sv
// Bench for the carry-save serial multiplier.
module tb_csa_serial_multiplier;

  localparam int W   = 8;
  localparam int P   = 2 * W;
  localparam int TMO = 3 * W;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [P-1:0] exp_q[$];

  csa_serial_multiplier_if #(.WIDTH(W)) ifc ();

  csa_serial_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n            = 1'b0;
    ifc.start        = 1'b0;
    ifc.multiplicand = '0;
    ifc.multiplier   = '0;
  end

  // ---------------- helpers ----------------
  function automatic logic [P-1:0] resolved();
    logic [P-1:0] c2;
    c2 = {ifc.carry[P-2:0], 1'b0};
    return ifc.sum + c2;
  endfunction

  function automatic logic [P-1:0] model_product(input int xi, input int yi);
    int p;
    p = xi * yi;
    return P'(p);
  endfunction

  // Called at a negedge: request one product and record its expected value.
  // Returns at the negedge following the sampling edge, start deasserted.
  task automatic drive_start(input int xi, input int yi, input logic [P-1:0] expv);
    ifc.start        = 1'b1;
    ifc.multiplicand = W'(xi);
    ifc.multiplier   = W'(yi);
    exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Counts edges after the sampling edge until done is seen (bounded).
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (edges < TMO) begin
      if (ifc.busy === 1'b1) busy_cycles++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ifc.done === 1'b1) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy);
    end
    checks++;
    if (ifc.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", ifc.done);
    end
    checks++;
    if (ifc.sum !== '0 || ifc.carry !== '0) begin
      errors++; $display("FAIL reset_vectors sum=%h carry=%h exp=0", ifc.sum, ifc.carry);
    end
    checks++;
    if (ifc.dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", ifc.dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.dbg_state !== 2'd0) begin
      errors++; $display("FAIL idle_after_reset busy=%b state=%0d exp busy=0 state=0",
                         ifc.busy, ifc.dbg_state);
    end
  endtask

  task automatic test_basic();
    int edges, busy_cycles;
    logic [P-1:0] expv, got;
    drive_start(3, 5, 16'h000F);
    wait_done(edges, busy_cycles);
    checks++;
    if (edges !== W || ifc.done !== 1'b1) begin
      errors++; $display("FAIL basic_latency edges=%0d done=%b exp edges=%0d done=1", edges, ifc.done, W);
    end
    checks++;
    if (busy_cycles !== W) begin
      errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cycles, W);
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done got=%b exp=0", ifc.busy);
    end
    got  = resolved();
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL basic_product got=%h exp=%h", got, expv);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0 || ifc.dbg_state !== 2'd0) begin
      errors++; $display("FAIL done_pulse_width done=%b state=%0d exp done=0 state=0", ifc.done, ifc.dbg_state);
    end
    got = resolved();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL hold_in_idle got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_corners();
    int xs[6]        = '{-128, -128, 127,  0,  -1, 1};
    int ys[6]        = '{-128,  127,  -1, -77, -1, -128};
    logic [P-1:0] es[6] = '{16'h4000, 16'hC080, 16'hFF81, 16'h0000, 16'h0001, 16'hFF80};
    int edges, busy_cycles;
    logic [P-1:0] expv, got;
    for (int i = 0; i < 6; i++) begin
      drive_start(xs[i], ys[i], es[i]);
      wait_done(edges, busy_cycles);
      checks++;
      if (edges !== W || ifc.done !== 1'b1) begin
        errors++; $display("FAIL corner%0d_latency edges=%0d exp=%0d", i, edges, W);
      end
      got  = resolved();
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL corner%0d_product x=%0d y=%0d got=%h exp=%h", i, xs[i], ys[i], got, expv);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cycles;
    logic [P-1:0] expv, got;
    drive_start(11, -13, 16'hFF71);
    wait_done(edges, busy_cycles);
    got  = resolved();
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv || ifc.done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_product got=%h done=%b exp=%h done=1", got, ifc.done, expv);
    end
    // Still in the DONE cycle: request the next product right away.
    drive_start(-7, 9, 16'hFFC1);
    checks++;
    if (ifc.busy !== 1'b1 || ifc.done !== 1'b0 || ifc.dbg_state !== 2'd1) begin
      errors++; $display("FAIL b2b_no_idle busy=%b done=%b state=%0d exp busy=1 done=0 state=1",
                         ifc.busy, ifc.done, ifc.dbg_state);
    end
    wait_done(edges, busy_cycles);
    checks++;
    if (edges !== W || ifc.done !== 1'b1) begin
      errors++; $display("FAIL b2b_latency edges=%0d exp=%0d", edges, W);
    end
    got  = resolved();
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL b2b_second_product got=%h exp=%h", got, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_run();
    int edges;
    logic [P-1:0] expv, got;
    drive_start(5, 6, 16'h001E);
    edges = 0;
    while (edges < TMO) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 3) begin
        ifc.start        = 1'b1;
        ifc.multiplicand = W'(-50);
        ifc.multiplier   = W'(100);
      end else begin
        ifc.start = 1'b0;
      end
      if (ifc.done === 1'b1) break;
    end
    checks++;
    if (edges !== W || ifc.done !== 1'b1) begin
      errors++; $display("FAIL midrun_latency edges=%0d exp=%0d", edges, W);
    end
    got  = resolved();
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL midrun_product got=%h exp=%h", got, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int edges, busy_cycles;
    logic [P-1:0] expv, got;
    // Aborted operation: nothing is expected from it.
    ifc.start        = 1'b1;
    ifc.multiplicand = W'(9);
    ifc.multiplier   = W'(9);
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags busy=%b done=%b exp 0/0", ifc.busy, ifc.done);
    end
    checks++;
    if (ifc.sum !== '0 || ifc.carry !== '0 || ifc.dbg_state !== 2'd0) begin
      errors++; $display("FAIL async_reset_vectors sum=%h carry=%h state=%0d exp 0", ifc.sum, ifc.carry, ifc.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_start(2, -3, 16'hFFFA);
    wait_done(edges, busy_cycles);
    checks++;
    if (edges !== W || ifc.done !== 1'b1) begin
      errors++; $display("FAIL post_reset_latency edges=%0d exp=%0d", edges, W);
    end
    got  = resolved();
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL post_reset_product got=%h exp=%h", got, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int xi, yi, edges, busy_cycles;
    logic [P-1:0] expv, got;
    for (int i = 0; i < 8; i++) begin
      xi = int'($urandom_range(0, 255)) - 128;
      yi = int'($urandom_range(0, 255)) - 128;
      drive_start(xi, yi, model_product(xi, yi));
      wait_done(edges, busy_cycles);
      checks++;
      if (edges !== W || ifc.done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_latency edges=%0d exp=%0d", i, edges, W);
      end
      got  = resolved();
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL rand%0d_product x=%0d y=%0d got=%h exp=%h", i, xi, yi, got, expv);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_start_during_run();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
